// File: rtl/jpeg_frame_src.sv
// jpeg_frame_src: streams a stored frame to a JPEG encoder in raster or 8x8-tiled order,
// honouring encoder backpressure through a single pending-pixel stage behind the memory read.
module jpeg_frame_src #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8,
  parameter int TILED = 0,
  localparam int DEPTH = IMG_W * IMG_H,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             start,
  input  logic [15:0]      num_frames,
  input  logic             stop,
  input  logic             full,
  output logic [PIX_W-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             frame_done
);
  localparam int BW = IMG_W / 8;
  localparam int BH = IMG_H / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           r_state, w_next;
  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rdata, r_dout;
  logic [AW-1:0]    r_a, r_bx, r_by, w_addr;
  logic [2:0]       r_c, r_r;
  logic [15:0]      r_nf, r_fcnt;
  logic             r_pv, r_pl, r_stop;
  logic             w_rd, w_xfer, w_last, w_fin;

  assign w_rd   = r_state == RUN && !full;
  assign w_xfer = r_pv && !full;
  assign w_last = TILED != 0
    ? (r_c == 3'd7 && r_r == 3'd7 && r_bx == AW'(BW - 1) && r_by == AW'(BH - 1))
    : r_a == AW'(DEPTH - 1);
  assign w_addr = TILED != 0
    ? AW'((int'(r_by) * 8 + int'(r_r)) * IMG_W + int'(r_bx) * 8 + int'(r_c))
    : r_a;
  // The frame being issued always equals frames completed, since a frame outlasts the one-deep pipe.
  assign w_fin  = r_stop || stop || (r_nf != 16'd0 && r_fcnt == r_nf - 16'd1);

  assign dout_valid = w_xfer;
  assign frame_done = w_xfer && r_pl;
  assign busy       = r_state != IDLE;
  assign dout       = w_xfer ? r_rdata : r_dout;

  always_ff @(posedge clk) begin
    if (wr_en && r_state == IDLE) r_mem[wr_addr] <= wr_data;
    if (w_rd) r_rdata <= r_mem[w_addr];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? RUN : IDLE)
           : r_state == RUN  ? (w_rd && w_last && w_fin ? DRAIN : RUN)
           : (w_xfer ? IDLE : DRAIN);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pv   <= 1'b0;
      r_pl   <= 1'b0;
      r_stop <= 1'b0;
      r_dout <= '0;
      r_nf   <= '0;
      r_fcnt <= '0;
      r_a    <= '0;
      r_bx   <= '0;
      r_by   <= '0;
      r_c    <= '0;
      r_r    <= '0;
    end else begin
      r_pv   <= w_rd || (r_pv && full);
      r_stop <= busy && (r_stop || stop);
      if (w_rd) r_pl <= w_last;
      if (w_xfer) r_dout <= r_rdata;
      if (frame_done) r_fcnt <= r_fcnt + 16'd1;
      if (r_state == IDLE && start) begin
        r_nf   <= num_frames;
        r_fcnt <= '0;
        r_a    <= '0;
        r_bx   <= '0;
        r_by   <= '0;
        r_c    <= '0;
        r_r    <= '0;
      end else if (w_rd) begin
        r_a <= r_a == AW'(DEPTH - 1) ? '0 : r_a + 1'b1;
        r_c <= r_c + 3'd1;
        if (r_c == 3'd7) begin
          r_r <= r_r + 3'd1;
          if (r_r == 3'd7) begin
            r_bx <= r_bx == AW'(BW - 1) ? '0 : r_bx + 1'b1;
            if (r_bx == AW'(BW - 1)) r_by <= r_by == AW'(BH - 1) ? '0 : r_by + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/jpeg_frame_src.md
JPEG_FRAME_SRC -- requirements
Module: jpeg_frame_src

Interface
- REQ-001 Parameter IMG_W, default 128: frame width in pixels; a multiple of 8, at least 8.
- REQ-002 Parameter IMG_H, default 128: frame height in pixels; a multiple of 8, at least 8.
- REQ-003 Parameter PIX_W, default 8: pixel width in bits.
- REQ-004 Parameter TILED, default 0: 0 selects raster scan order; 1 selects 8x8 block-tiled scan order.
- REQ-005 Derived constants: DEPTH = IMG_W*IMG_H, AW = $clog2(DEPTH).
- REQ-006 clk  in  1  single clock; all logic is on the rising edge.
- REQ-007 nrst  in  1  asynchronous, active-low reset.
- REQ-008 wr_en  in  1  frame-memory write strobe.
- REQ-009 wr_addr  in  AW  frame-memory write address.
- REQ-010 wr_data  in  PIX_W  frame-memory write data.
- REQ-011 start  in  1  single-cycle request to begin streaming.
- REQ-012 num_frames  in  16  number of frames to stream, sampled at start; 0 means continuous.
- REQ-013 stop  in  1  requests a halt at the next frame boundary.
- REQ-014 full  in  1  encoder backpressure; 1 means no pixel may be presented.
- REQ-015 dout  out  PIX_W  pixel presented to the encoder's din port.
- REQ-016 dout_valid  out  1  dout carries a transferred pixel this cycle.
- REQ-017 busy  out  1  streaming is in progress.
- REQ-018 frame_done  out  1  single-cycle pulse, asserted with the last pixel of each frame.

Function
- REQ-019 The frame memory SHALL have DEPTH x PIX_W entries, a synchronous read with 1-cycle latency, and a write port that is independent of the read port.
- REQ-020 A write SHALL take effect only when wr_en=1 and busy=0; writes while busy=1 are ignored.
- REQ-021 The FSM SHALL have three states: IDLE, RUN and DRAIN.
  - IDLE to RUN: on start=1.
  - RUN to DRAIN: after the last read of the final frame has been issued.
  - DRAIN to IDLE: once the last pixel has been emitted.
- REQ-022 In IDLE, start SHALL latch num_frames and reset the scan and frame counters to 0; start is ignored in RUN and DRAIN.
- REQ-023 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
- REQ-024 Raster order SHALL read addresses 0, 1, ..., DEPTH-1.
- REQ-025 Tiled order SHALL use loop order by, bx, r, c (outermost to innermost) with addr = (by*8+r)*IMG_W + bx*8 + c, where by < IMG_H/8, bx < IMG_W/8, and r, c < 8.
- REQ-026 A pixel SHALL transfer exactly on cycles where dout_valid=1.
- REQ-027 While full=1, dout_valid SHALL be 0 and the scan position SHALL hold.
- REQ-028 Across any full pattern, no pixel SHALL be lost, duplicated or reordered.
- REQ-029 With full=0 throughout, the first dout_valid SHALL appear 2 cycles after the start cycle, and one pixel SHALL be emitted per cycle after that.
- REQ-030 Across consecutive frames there SHALL be no gap: pixel 0 of frame n+1 follows the last pixel of frame n on the next cycle when full=0.
- REQ-031 frame_done SHALL equal 1 exactly on the cycle the last pixel of a frame is emitted (dout_valid=1 on the same cycle).
- REQ-032 The frame counter SHALL be 16 bits, increment on frame_done, and wrap at 2^16 in continuous mode.
- REQ-033 Streaming SHALL end after num_frames frames, or, with num_frames=0, never, unless stopped.
- REQ-034 stop=1, in any cycle while busy, SHALL be latched; the current frame then completes and the block goes to IDLE with no further frames.
- REQ-035 If stop and the final frame's frame_done coincide, there SHALL be a single termination with no extra frame.
- REQ-036 dout SHALL hold its last value whenever dout_valid=0.

Reset
- REQ-037 While nrst=0, all state SHALL clear asynchronously: FSM=IDLE, dout=0, dout_valid=0, busy=0, frame_done=0, counters=0, stop latch=0.
- REQ-038 Frame-memory contents SHALL be left unreset.
- REQ-039 Reset asserted mid-frame SHALL abort immediately, with no partial frame_done.
- REQ-040 After release, the block SHALL remain in IDLE until start.

Verification
- REQ-041 Raster, single frame: load mem[i] = i mod 256, IMG_W = IMG_H = 16, num_frames=1, full=0 -> 256 pixels 00..FF on consecutive cycles starting at start+2; frame_done with FF; busy falls the cycle after.
- REQ-042 Tiled, single frame: same image, TILED=1 -> first 9 pixels 00..07, 10; pixel 64 = 08; last pixel FF with frame_done.
- REQ-043 Backpressure: full driven by a random 50% pattern -> the emitted sequence is identical to REQ-041, and dout_valid=0 on every full=1 cycle.
- REQ-044 Multi-frame: num_frames=3 -> 768 contiguous pixels, frame_done 3 times spaced 256 cycles apart, then IDLE.
- REQ-045 Stop and guards: num_frames=0 with stop pulsed mid-frame 2 -> frame 2 completes and no frame 3 begins; wr_en during busy leaves memory unchanged.
- REQ-046 Reset mid-run: nrst low at pixel 100 -> outputs 0 within the same cycle; after release with no start, no dout_valid appears.
